store_unit: RTL

Store-path counterpart of the load byte-extraction logic in the Pipelined_BRAM core. It accepts sb/sh/sw requests from the MEM stage and lane-aligns the write data. It generates per-byte write enables and queues stores in a small FIFO store buffer. The buffer drains into the shared data BRAM port whenever no load owns that port. It flags misaligned stores and reports load-after-store address hazards to the hazard unit.

---
 rtl/store_unit_if.sv | 40 ++++
 rtl/store_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/store_unit_if.sv
// store_unit_if: bundle of the store-request, load-port and BRAM-write signals
// of the store unit. The unit itself connects through the slave modport; the
// MEM stage / bench side drives through the master modport.
//   store request : st_valid, st_ready, ALUResult, WriteData, ByteAccess
//   load port     : ld_req, ld_addr, ld_hazard
//   BRAM write    : bram_en, bram_we, bram_addr, bram_wdata
//   status        : misalign_fault, count
interface store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] ALUResult;
  logic [31:0]       WriteData;
  logic [2:0]        ByteAccess;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-3:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic              misalign_fault;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  st_valid, ALUResult, WriteData, ByteAccess, ld_req, ld_addr,
    output st_ready, ld_hazard, bram_en, bram_we, bram_addr, bram_wdata,
           misalign_fault, count
  );

  modport master (
    output st_valid, ALUResult, WriteData, ByteAccess, ld_req, ld_addr,
    input  st_ready, ld_hazard, bram_en, bram_we, bram_addr, bram_wdata,
           misalign_fault, count
  );
endinterface

// File: rtl/store_unit.sv
// store_unit: store path of the data-BRAM port. Encodes sb/sh/sw requests into
// {word addr, byte enables, lane-replicated data}, queues them in a DEPTH-entry
// FIFO and drains one entry per cycle into the BRAM whenever no load owns the
// port. Misaligned stores are dropped with a one-cycle fault pulse; loads that
// hit a buffered word raise ld_hazard combinationally.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - store_unit_if.slave (request, load port, BRAM write, status)

// Per-entry hazard comparator: an entry hits when it lies inside the occupied
// window [rd_ptr, rd_ptr+count) and holds the load's word address.
module store_unit_hzd #(
  parameter int PTR_W = 2,
  parameter int CNT_W = 3,
  parameter int WA_W  = 30
) (
  input  logic [PTR_W-1:0] idx,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [CNT_W-1:0] count,
  input  logic [WA_W-1:0]  ent_addr,
  input  logic [WA_W-1:0]  ld_waddr,
  output logic             hit
);
  logic [PTR_W-1:0] ofs;

  // distance from head wraps modulo DEPTH because PTR_W = log2(DEPTH)
  assign ofs = idx - rd_ptr;
  assign hit = ({1'b0, ofs} < count) && (ent_addr == ld_waddr);
endmodule

module store_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  store_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef struct packed {
    logic [WA_W-1:0] waddr;
    logic [3:0]      we;
    logic [31:0]     wdata;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  logic [1:0]       sz;
  logic [1:0]       boff;
  logic             mis;
  ent_t             enc;
  logic             full, empty, push, pop;
  ent_t             head;
  logic [DEPTH-1:0] hits;
  logic             unused_bits;

  assign unused_bits = ^{bus.ByteAccess[2], bus.ld_addr[1:0]};

  assign sz   = bus.ByteAccess[1:0];
  assign boff = bus.ALUResult[1:0];

  // Encode before enqueue so the drain side is a plain register read.
  always_comb begin
    enc.waddr = bus.ALUResult[ADDR_W-1:2];
    enc.we    = 4'b1111;
    enc.wdata = bus.WriteData;
    mis       = 1'b0;
    case (sz)
      2'b01: begin
        enc.we    = 4'b0001 << boff;
        enc.wdata = {4{bus.WriteData[7:0]}};
      end
      2'b10: begin
        enc.we    = 4'b0011 << {boff[1], 1'b0};
        enc.wdata = {2{bus.WriteData[15:0]}};
        mis       = boff[0];
      end
      default: begin
        // 00 and 11 are both word stores
        mis = (boff != 2'b00);
      end
    endcase
  end

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.st_valid && !full && !mis;
  assign pop   = !empty && !bus.ld_req;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // a misaligned request is consumed (not held) but never stored
      fault_q <= bus.st_valid && !full && mis;
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Hazard window is the current occupancy, so the head being popped this
  // cycle still counts and the store being enqueued does not.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hzd
    store_unit_hzd #(.PTR_W(PTR_W), .CNT_W(CNT_W), .WA_W(WA_W)) u_hzd (
      .idx      (PTR_W'(g)),
      .rd_ptr   (rd_ptr),
      .count    (cnt_q),
      .ent_addr (mem[g].waddr),
      .ld_waddr (bus.ld_addr[ADDR_W-1:2]),
      .hit      (hits[g])
    );
  end

  assign bus.ld_hazard      = bus.ld_req && (|hits);
  assign bus.st_ready       = !full;
  assign bus.count          = cnt_q;
  assign bus.misalign_fault = fault_q;
  assign bus.bram_en        = pop;
  // idle port shows zeros rather than stale head contents
  assign bus.bram_we        = pop ? head.we    : 4'b0000;
  assign bus.bram_addr      = pop ? head.waddr : '0;
  assign bus.bram_wdata     = pop ? head.wdata : 32'h0;
endmodule
